// File: rtl/csr_timer_bank_pkg.sv
// Shared definitions for the CSR timer bank: register map, CFG bit layout, defaults.
// Latency: n/a (constants and a pure packing function).
// Backpressure: n/a.
package csr_timer_bank_pkg;

    localparam int CNT_W_DEFAULT = 64;

    // Global register word indices
    localparam int ADDR_CTRL     = 'h00;
    localparam int ADDR_PRESC    = 'h01;
    localparam int ADDR_MTIME_LO = 'h02;
    localparam int ADDR_MTIME_HI = 'h03;

    // Channel c occupies CH_BASE + CH_STRIDE*c + offset
    localparam int CH_BASE    = 'h10;
    localparam int CH_STRIDE  = 4;
    localparam int OFF_CMP_LO = 0;
    localparam int OFF_CMP_HI = 1;
    localparam int OFF_PER    = 2;
    localparam int OFF_CFG    = 3;

    // CFG register bit positions
    localparam int CFG_EN       = 0;
    localparam int CFG_IE       = 1;
    localparam int CFG_PERIODIC = 2;
    localparam int CFG_PEND     = 8;

    function automatic logic [31:0] cfg_pack(input logic en, input logic ie,
                                             input logic periodic, input logic pend);
        logic [31:0] w;
        w               = '0;
        w[CFG_EN]       = en;
        w[CFG_IE]       = ie;
        w[CFG_PERIODIC] = periodic;
        w[CFG_PEND]     = pend;
        return w;
    endfunction

endpackage

// File: rtl/csr_timer_bank_cmp_ch.sv
// One compare channel: cmp/PER/CFG/PEND state, match compare, reload adder, irq register.
// Latency: PEND sets one edge after match; irq follows PEND by one more edge.
// Backpressure: none; CSR writes always accepted in the cycle they are presented.
//
// Ports: clk/rst_n; mtime (live timer); per-register write strobes plus shared wdata;
// readback words for CMP_LO/CMP_HI/PER/CFG; irq_term (PEND & IE, unregistered) and irq.
module timer_cmp_ch
    import csr_timer_bank_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] mtime,
    input  logic             cmp_lo_we,
    input  logic             cmp_hi_we,
    input  logic             per_we,
    input  logic             cfg_we,
    input  logic [31:0]      wdata,
    output logic [31:0]      cmp_lo_rd,
    output logic [31:0]      cmp_hi_rd,
    output logic [31:0]      per_rd,
    output logic [31:0]      cfg_rd,
    output logic             irq_term,
    output logic             irq
);

    logic [CNT_W-1:0] cmp_q;
    logic [CNT_W-1:0] cmp_d;
    logic [31:0]      per_q;
    logic             en_q;
    logic             ie_q;
    logic             periodic_q;
    logic             pend_q;
    logic             match;
    logic [63:0]      cmp_ext;

    // Zero-extended view so HI accesses work for any CNT_W in 32..64;
    // with CNT_W=32 the truncating casts below drop HI writes naturally.
    assign cmp_ext = 64'(cmp_q);
    assign match   = en_q && (mtime >= cmp_q);

    // A software write to either half takes priority over the periodic advance.
    always_comb begin
        cmp_d = cmp_q;
        if (cmp_lo_we) begin
            cmp_d = CNT_W'({cmp_ext[63:32], wdata});
        end else if (cmp_hi_we) begin
            cmp_d = CNT_W'({wdata, cmp_ext[31:0]});
        end else if (match && periodic_q) begin
            cmp_d = cmp_q + CNT_W'(per_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q      <= '0;
            per_q      <= '0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            periodic_q <= 1'b0;
            pend_q     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            if (per_we) begin
                per_q <= wdata;
            end
            if (cfg_we) begin
                en_q       <= wdata[CFG_EN];
                ie_q       <= wdata[CFG_IE];
                periodic_q <= wdata[CFG_PERIODIC];
            end else if (match && !periodic_q) begin
                en_q <= 1'b0;
            end
            // Hardware set beats a simultaneous W1C.
            pend_q <= match | (pend_q & ~(cfg_we & wdata[CFG_PEND]));
            irq    <= pend_q & ie_q;
        end
    end

    assign irq_term  = pend_q & ie_q;
    assign cmp_lo_rd = cmp_ext[31:0];
    assign cmp_hi_rd = cmp_ext[63:32];
    assign per_rd    = per_q;
    assign cfg_rd    = cfg_pack(en_q, ie_q, periodic_q, pend_q);

endmodule

// File: rtl/csr_timer_bank.sv
// Prescaled machine timer with NUM_CH compare channels on a 32-bit CSR port.
// Latency: writes land at the clock edge; reads are combinational; irq is one edge after PEND.
// Backpressure: none; the CSR port never stalls. Optional macro: TIMER_SNAPSHOT_EN
//
// Ports: clk, rst_n (async active-low); csr_we_i/csr_re_i/csr_addr_i/csr_wdata_i/csr_rdata_o
// CSR port; halt_i debug freeze; mtime_o live timer; irq_o per-channel irq; irq_any_o OR of irqs.
// TIMER_SNAPSHOT_EN: a MTIME_LO read latches the upper timer word so MTIME_HI reads tear-free.
module csr_timer_bank
    import csr_timer_bank_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csr_we_i,
    input  logic              csr_re_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic [31:0]       csr_wdata_i,
    output logic [31:0]       csr_rdata_o,
    input  logic              halt_i,
    output logic [CNT_W-1:0]  mtime_o,
    output logic [NUM_CH-1:0] irq_o,
    output logic              irq_any_o
);

    logic               ten_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   mtime_q;
    logic [63:0]        mtime_ext;
    logic               tick;
    logic               we_ctrl;
    logic               we_presc;
    logic               we_mtime_lo;
    logic               we_mtime_hi;
    logic [NUM_CH-1:0]  irq_terms;
    logic [31:0]        ch_cmp_lo [NUM_CH];
    logic [31:0]        ch_cmp_hi [NUM_CH];
    logic [31:0]        ch_per    [NUM_CH];
    logic [31:0]        ch_cfg    [NUM_CH];
    logic [31:0]        mtime_hi_rd;

    assign we_ctrl     = csr_we_i && (csr_addr_i == ADDR_W'(ADDR_CTRL));
    assign we_presc    = csr_we_i && (csr_addr_i == ADDR_W'(ADDR_PRESC));
    assign we_mtime_lo = csr_we_i && (csr_addr_i == ADDR_W'(ADDR_MTIME_LO));
    assign we_mtime_hi = csr_we_i && (csr_addr_i == ADDR_W'(ADDR_MTIME_HI));

    assign mtime_ext = 64'(mtime_q);
    assign mtime_o   = mtime_q;
    assign tick      = ten_q && !halt_i && (presc_cnt == presc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ten_q   <= 1'b0;
            presc_q <= '0;
        end else begin
            if (we_ctrl) begin
                ten_q <= csr_wdata_i[0];
            end
            if (we_presc) begin
                presc_q <= csr_wdata_i[PRESC_W-1:0];
            end
        end
    end

    // Prescaler restarts its phase whenever the divide value changes or the timer is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (we_presc || !ten_q) begin
            presc_cnt <= '0;
        end else if (!halt_i) begin
            presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
        end
    end

    // A software write to either half suppresses that cycle's increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q <= '0;
        end else if (we_mtime_lo) begin
            mtime_q <= CNT_W'({mtime_ext[63:32], csr_wdata_i});
        end else if (we_mtime_hi) begin
            mtime_q <= CNT_W'({csr_wdata_i, mtime_ext[31:0]});
        end else if (tick) begin
            mtime_q <= mtime_q + CNT_W'(1);
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (csr_re_i && (csr_addr_i == ADDR_W'(ADDR_MTIME_LO))) begin
            shadow_q <= mtime_ext[63:32];
        end
    end

    assign mtime_hi_rd = shadow_q;
`else
    // The read strobe only has side effects when the snapshot shadow is built.
    logic unused_re;
    assign unused_re   = csr_re_i;
    assign mtime_hi_rd = mtime_ext[63:32];
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam int BASE = CH_BASE + CH_STRIDE * g;

        timer_cmp_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .mtime     (mtime_q),
            .cmp_lo_we (csr_we_i && (csr_addr_i == ADDR_W'(BASE + OFF_CMP_LO))),
            .cmp_hi_we (csr_we_i && (csr_addr_i == ADDR_W'(BASE + OFF_CMP_HI))),
            .per_we    (csr_we_i && (csr_addr_i == ADDR_W'(BASE + OFF_PER))),
            .cfg_we    (csr_we_i && (csr_addr_i == ADDR_W'(BASE + OFF_CFG))),
            .wdata     (csr_wdata_i),
            .cmp_lo_rd (ch_cmp_lo[g]),
            .cmp_hi_rd (ch_cmp_hi[g]),
            .per_rd    (ch_per[g]),
            .cfg_rd    (ch_cfg[g]),
            .irq_term  (irq_terms[g]),
            .irq       (irq_o[g])
        );
    end

    // Registered from the same PEND & IE terms as irq_o, so both move together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_any_o <= 1'b0;
        end else begin
            irq_any_o <= |irq_terms;
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        if (csr_addr_i == ADDR_W'(ADDR_CTRL)) begin
            csr_rdata_o = {31'b0, ten_q};
        end else if (csr_addr_i == ADDR_W'(ADDR_PRESC)) begin
            csr_rdata_o = 32'(presc_q);
        end else if (csr_addr_i == ADDR_W'(ADDR_MTIME_LO)) begin
            csr_rdata_o = mtime_ext[31:0];
        end else if (csr_addr_i == ADDR_W'(ADDR_MTIME_HI)) begin
            csr_rdata_o = mtime_hi_rd;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (csr_addr_i == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_CMP_LO)) begin
                csr_rdata_o = ch_cmp_lo[c];
            end
            if (csr_addr_i == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_CMP_HI)) begin
                csr_rdata_o = ch_cmp_hi[c];
            end
            if (csr_addr_i == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_PER)) begin
                csr_rdata_o = ch_per[c];
            end
            if (csr_addr_i == ADDR_W'(CH_BASE + CH_STRIDE * c + OFF_CFG)) begin
                csr_rdata_o = ch_cfg[c];
            end
        end
    end

endmodule

// File: doc/csr_timer_bank.md
Name: csr_timer_bank

Overview:
- Parametrised successor to the core CSR timer logic.
- Provides one shared prescaled 64-bit-class machine timer and NUM_CH independent compare channels.
- Each channel runs in one-shot or periodic (auto-reload) mode and has its own pending flag and interrupt enable.
- Sits beside the CSR file on the same 32-bit CSR write/read port and drives per-channel interrupt lines into trap handling.

Parameters:
- NUM_CH, 4, number of compare channels (1..8).
- CNT_W, 64, timer and compare width in bits (32..64); HI words carry bits [CNT_W-1:32], zero-extended.
- PRESC_W, 16, prescaler divide-value width.
- ADDR_W, 8, CSR port address width (word index).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- csr_we_i  in  1  write enable; write takes effect at the clock edge.
- csr_re_i  in  1  read strobe; qualifies read side effects.
- csr_addr_i  in  ADDR_W  register word index.
- csr_wdata_i  in  32  write data.
- csr_rdata_o  out  32  read data, combinational from csr_addr_i.
- halt_i  in  1  debug freeze: blocks the prescaler and mtime when high.
- mtime_o  out  CNT_W  live timer value.
- irq_o  out  NUM_CH  per-channel interrupt, registered.
- irq_any_o  out  1  OR of irq_o, registered.

Behaviour:
- Register map:
  - 0x00 CTRL: [0] TEN (timer enable).
  - 0x01 PRESC: [PRESC_W-1:0] divide value.
  - 0x02 MTIME_LO.
  - 0x03 MTIME_HI.
  - Channel c at base 0x10+4c: +0 CMP_LO, +1 CMP_HI, +2 PER (32-bit reload step), +3 CFG.
  - CFG bits: [0] EN, [1] IE, [2] PERIODIC, [8] PEND. PEND is read; writing 1 clears it (W1C).
  - Unmapped addresses read 0 and ignore writes.
- Reset values: all registers 0; mtime 0; irq_o 0; irq_any_o 0; csr_rdata_o follows the address decode (0 for unmapped).
- Prescaler:
  - presc_cnt counts 0..PRESC while TEN=1 and halt_i=0.
  - tick is asserted in the cycle presc_cnt==PRESC; presc_cnt then wraps to 0.
  - PRESC=0 gives a tick every cycle.
  - Writing PRESC or clearing TEN resets presc_cnt to 0.
- mtime:
  - Increments by 1 on tick, wrapping modulo 2^CNT_W.
  - A write to MTIME_LO or MTIME_HI replaces that half and suppresses the increment in that cycle.
- Channel match: when EN=1 and mtime >= cmp (unsigned, CNT_W wide), set PEND on the next edge.
  - One-shot (PERIODIC=0): EN clears in the same edge.
  - Periodic: cmp <= cmp + PER, wrapping mod 2^CNT_W.
  - Periodic with PER=0: cmp is not advanced, so PEND re-asserts every cycle.
- Simultaneous events:
  - Hardware set and software W1C of PEND in the same cycle: set wins.
  - Software CMP write and periodic advance in the same cycle: software value wins.
  - Software CFG write clearing EN in a match cycle: PEND still sets; EN stays 0.
- Interrupts:
  - irq_o[c] = registered (PEND[c] & IE[c]), one cycle after PEND becomes visible.
  - irq_any_o is registered from the same terms, so it is cycle-aligned with irq_o.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); no pending survives.
- Writes to the HI registers when CNT_W=32 are ignored; those reads return 0.

Optional Feature:
- Macro: TIMER_SNAPSHOT_EN.
- Defined:
  - A read of MTIME_LO (csr_re_i=1) latches mtime[CNT_W-1:32] into a shadow register.
  - MTIME_HI reads return the shadow, giving a tear-free 64-bit read.
  - The shadow resets to 0.
- Undefined: MTIME_HI returns live mtime bits, and the shadow register is not built.

Decomposition:
- Shared package holds:
  - register offsets (CTRL, PRESC, MTIME_LO/HI, channel base and stride, CMP_LO/HI, PER, CFG);
  - CFG bit positions;
  - default CNT_W.
- Sub-module timer_cmp_ch, instantiated NUM_CH times via generate, holds per channel:
  - cmp, PER, CFG and PEND state;
  - match compare and reload adder;
  - the irq register.
- Top level holds the prescaler, mtime, the snapshot shadow, address decode and the read mux.

Test Plan:
1. Prescaler: PRESC=3, TEN=1 -> mtime increments once every 4 cycles; set halt_i for 10 cycles -> mtime frozen; TEN=0 -> mtime held and presc_cnt=0.
2. One-shot: ch0 CMP=20, IE=1, EN=1, PRESC=0 -> PEND sets when mtime reaches 20; irq_o[0] one cycle later; EN reads 0; W1C PEND -> irq_o[0] falls next cycle.
3. Periodic: ch1 CMP=10, PER=5, PERIODIC=1 -> PEND at mtime 10, 15 and 20, clearing it each time; CMP_LO reads 25 after the third match; with CMP=0xFFFF_FFFF_FFFF_FFFE and PER=4, the next cmp wraps to 2.
4. Collisions: W1C PEND in the same cycle as a hardware match -> PEND=1; CMP_LO write coincident with a periodic advance -> the written value is kept.
5. Snapshot (TIMER_SNAPSHOT_EN): mtime=0x0000_0001_FFFF_FFFF; read LO; the timer rolls over; read HI -> returns 1, not 2. Same sequence without the macro -> returns 2.
6. Asynchronous reset asserted while ch0 PEND=1 and irq_o=1 -> irq_o, irq_any_o, mtime and all CFG registers read 0 with no clock edge.
